// File: rtl/dec_to_bin.sv
// ---------------------------------------------------------------------------
// dec_to_bin
//
// Converts an operator-entered BCD temperature (sign, hundreds, tens, units,
// tenths) into the DS18B20 12-bit two's-complement format (1/16 degC per LSB,
// sign-extended to 16 bits), plus the signed 8-bit integer used for TH/TL
// alarm-register writes.
//
// The integer part is converted by counting the BCD value down to zero while
// counting a binary register up, one step per F1M-qualified clk edge. An
// integer value N takes N+2 F1M edges from load to done.
//
// Optional feature: define DEC_TO_BIN_CLAMP_EN to saturate results whose
// magnitude exceeds MAX_POS.0 (positive) or MAX_NEG.0 (negative) and flag
// them on out_of_range. Without it, integers above 127 wrap and
// out_of_range is tied low.
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   F1M             clock enable; state advances only on edges with F1M=1
//   dec_temperature BCD input [15:12] hundreds .. [3:0] tenths
//   dec_sign        1 = negative
//   convert_en      start request, sampled only while idle
//   busy            high from load edge until finish edge
//   done            one-clk pulse when results update
//   bcd_err         last request had a digit >9 (sticky until next load)
//   out_of_range    last result was saturated
//   bin_temperature DS18B20 format, sign-extended to 16 bits
//   bin_integer     signed integer part, truncated toward zero
// ---------------------------------------------------------------------------
module dec_to_bin #(
    parameter int MAX_POS = 125,
    parameter int MAX_NEG = 55
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        F1M,
    input  logic [15:0] dec_temperature,
    input  logic        dec_sign,
    input  logic        convert_en,
    output logic        busy,
    output logic        done,
    output logic        bcd_err,
    output logic        out_of_range,
    output logic [15:0] bin_temperature,
    output logic [7:0]  bin_integer
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COUNT  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    // Limits expressed in 1/16 degC so the whole magnitude (integer and
    // fraction) can be compared in one go.
    localparam logic [11:0] POS_LIM = 12'(MAX_POS * 16);
    localparam logic [11:0] NEG_LIM = 12'(MAX_NEG * 16);

    logic [1:0] state;
    logic [3:0] cnt_h, cnt_t, cnt_u;   // BCD down-counter (integer part)
    logic [7:0] cnt_bin;               // binary up-counter
    logic [3:0] frac4;                 // tenths converted to sixteenths
    logic       sign_q;

    logic [3:0] in_h, in_t, in_u, in_d;
    logic       digit_bad;
    logic       cnt_zero;

    assign in_h = dec_temperature[15:12];
    assign in_t = dec_temperature[11:8];
    assign in_u = dec_temperature[7:4];
    assign in_d = dec_temperature[3:0];

    assign digit_bad = (in_h > 4'd9) || (in_t > 4'd9) ||
                       (in_u > 4'd9) || (in_d > 4'd9);
    assign cnt_zero  = (cnt_h == 4'd0) && (cnt_t == 4'd0) && (cnt_u == 4'd0);

    // round(d * 1.6): tenths digit to nearest sixteenth
    function automatic logic [3:0] tenths_to_frac(input logic [3:0] d);
        case (d)
            4'd0:    tenths_to_frac = 4'd0;
            4'd1:    tenths_to_frac = 4'd2;
            4'd2:    tenths_to_frac = 4'd3;
            4'd3:    tenths_to_frac = 4'd5;
            4'd4:    tenths_to_frac = 4'd6;
            4'd5:    tenths_to_frac = 4'd8;
            4'd6:    tenths_to_frac = 4'd10;
            4'd7:    tenths_to_frac = 4'd11;
            4'd8:    tenths_to_frac = 4'd13;
            4'd9:    tenths_to_frac = 4'd14;
            default: tenths_to_frac = 4'd0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Result formatting, consumed on the FINISH edge
    // ------------------------------------------------------------------
    logic [10:0] mag11;
    logic [15:0] res_pos;
    logic [15:0] res_bin;
    logic [7:0]  res_int;
    logic        res_oor;

    always_comb begin
        // Only 7 integer bits fit the sensor format; bit 7 wraps away.
        mag11   = {cnt_bin[6:0], frac4};
        res_pos = {5'b0, mag11};
        res_bin = sign_q ? (16'd0 - res_pos) : res_pos;
        res_int = sign_q ? (8'd0 - cnt_bin) : cnt_bin;
        res_oor = 1'b0;
`ifdef DEC_TO_BIN_CLAMP_EN
        // Compare the full 12-bit magnitude so that e.g. 125.1 saturates
        // while 125.0 is still in range.
        if (!sign_q && ({cnt_bin, frac4} > POS_LIM)) begin
            res_bin = {4'b0, POS_LIM};
            res_int = 8'(MAX_POS);
            res_oor = 1'b1;
        end else if (sign_q && ({cnt_bin, frac4} > NEG_LIM)) begin
            res_bin = 16'd0 - {4'b0, NEG_LIM};
            res_int = 8'd0 - 8'(MAX_NEG);
            res_oor = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Control and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            cnt_h           <= 4'd0;
            cnt_t           <= 4'd0;
            cnt_u           <= 4'd0;
            cnt_bin         <= 8'd0;
            frac4           <= 4'd0;
            sign_q          <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            bcd_err         <= 1'b0;
            bin_temperature <= 16'h0000;
            bin_integer     <= 8'h00;
        end else begin
            // done is a single clk pulse even when F1M is slow.
            done <= 1'b0;
            if (F1M) begin
                case (state)
                    S_IDLE: begin
                        if (convert_en) begin
                            if (digit_bad) begin
                                bcd_err <= 1'b1;
                            end else begin
                                bcd_err <= 1'b0;
                                busy    <= 1'b1;
                                cnt_h   <= in_h;
                                cnt_t   <= in_t;
                                cnt_u   <= in_u;
                                cnt_bin <= 8'd0;
                                frac4   <= tenths_to_frac(in_d);
                                sign_q  <= dec_sign;
                                state   <= S_COUNT;
                            end
                        end
                    end

                    S_COUNT: begin
                        if (cnt_zero) begin
                            state <= S_FINISH;
                        end else begin
                            cnt_bin <= cnt_bin + 8'd1;
                            // decimal decrement with borrow
                            if (cnt_u != 4'd0) begin
                                cnt_u <= cnt_u - 4'd1;
                            end else begin
                                cnt_u <= 4'd9;
                                if (cnt_t != 4'd0) begin
                                    cnt_t <= cnt_t - 4'd1;
                                end else begin
                                    cnt_t <= 4'd9;
                                    cnt_h <= cnt_h - 4'd1;
                                end
                            end
                        end
                    end

                    S_FINISH: begin
                        bin_temperature <= res_bin;
                        bin_integer     <= res_int;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        state           <= S_IDLE;
                    end

                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef DEC_TO_BIN_CLAMP_EN
    logic oor_q;

    // Cleared by any accepted load, updated on the finish edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oor_q <= 1'b0;
        end else if (F1M) begin
            if (state == S_IDLE && convert_en && !digit_bad)
                oor_q <= 1'b0;
            else if (state == S_FINISH)
                oor_q <= res_oor;
        end
    end

    assign out_of_range = oor_q;
`else
    // Limits and saturation flag have no function in the wrapping build.
    logic unused_clamp;
    assign unused_clamp = ^{POS_LIM, NEG_LIM, res_oor};
    assign out_of_range = 1'b0;
`endif

endmodule

// File: tb/tb_dec_to_bin.sv
module tb_dec_to_bin;

    logic        clk;
    logic        rst_n;
    logic        F1M;
    logic [15:0] dec_temperature;
    logic        dec_sign;
    logic        convert_en;
    logic        busy;
    logic        done;
    logic        bcd_err;
    logic        out_of_range;
    logic [15:0] bin_temperature;
    logic [7:0]  bin_integer;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int period      = 1;

    // model's view of the last published result
    logic [15:0] exp_bin = 16'h0000;
    logic [7:0]  exp_int = 8'h00;
    logic        exp_oor = 1'b0;

    dec_to_bin dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .F1M             (F1M),
        .dec_temperature (dec_temperature),
        .dec_sign        (dec_sign),
        .convert_en      (convert_en),
        .busy            (busy),
        .done            (done),
        .bcd_err         (bcd_err),
        .out_of_range    (out_of_range),
        .bin_temperature (bin_temperature),
        .bin_integer     (bin_integer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        F1M = ((cyc % period) == 0);
    endtask

    task automatic set_period(input int p);
        period = p;
        F1M    = ((cyc % period) == 0);
    endtask

    // Reference: value arithmetic straight from the format definition.
    task automatic model(input int n, input int d, input bit s,
                         output logic [15:0] eb, output logic [7:0] ei, output logic eo);
        int frac, mag;
        frac = (d * 16 + 5) / 10;
        mag  = (n % 128) * 16 + frac;
        eb   = s ? 16'(-mag) : 16'(mag);
        ei   = s ? 8'(-n) : 8'(n);
        eo   = 1'b0;
`ifdef DEC_TO_BIN_CLAMP_EN
        if (!s && (n * 16 + frac) > 125 * 16) begin
            eb = 16'(125 * 16); ei = 8'(125); eo = 1'b1;
        end else if (s && (n * 16 + frac) > 55 * 16) begin
            eb = 16'(-(55 * 16)); ei = 8'(-55); eo = 1'b1;
        end
`endif
    endtask

    task automatic run_conv(input logic [15:0] bcd, input bit sgn, input string tag,
                            input bit poke, input int exp_cycles);
        int h, t, u, d, n, edges, cycles, busy_drop, done_seen;
        logic [15:0] eb; logic [7:0] ei; logic eo;
        bit f, bad, got;
        h = bcd[15:12]; t = bcd[11:8]; u = bcd[7:4]; d = bcd[3:0];
        bad = (h > 9) || (t > 9) || (u > 9) || (d > 9);
        n   = h * 100 + t * 10 + u;

        dec_temperature = bcd;
        dec_sign        = sgn;
        convert_en      = 1'b1;
        f = 1'b0;
        for (int k = 0; k < 16 && !f; k++) begin
            f = F1M;
            tick();
        end
        convert_en = 1'b0;
        chk({tag, "_accept"}, 16'(f), 16'd1);

        if (bad) begin
            chk({tag, "_bcd_err"}, 16'(bcd_err), 16'd1);
            chk({tag, "_busy"}, 16'(busy), 16'd0);
            done_seen = 0;
            for (int k = 0; k < 8; k++) begin
                if (done) done_seen++;
                tick();
            end
            chk({tag, "_no_done"}, 16'(done_seen), 16'd0);
            chk({tag, "_keep_bin"}, bin_temperature, exp_bin);
            chk({tag, "_keep_int"}, 16'(bin_integer), 16'(exp_int));
        end else begin
            model(n, d, sgn, eb, ei, eo);
            chk({tag, "_busy_on"}, 16'(busy), 16'd1);
            chk({tag, "_bcd_clr"}, 16'(bcd_err), 16'd0);
            chk({tag, "_oor_clr"}, 16'(out_of_range), 16'd0);
            edges = 0; cycles = 0; busy_drop = 0; got = 1'b0;
            while (!got && cycles < 2000) begin
                convert_en = poke && (edges >= 2) && (edges < 4);
                f = F1M;
                tick();
                cycles++;
                if (f) edges++;
                if (done) got = 1'b1;
                else if (busy !== 1'b1) busy_drop++;
            end
            convert_en = 1'b0;
            chk({tag, "_done_seen"}, 16'(got), 16'd1);
            chk({tag, "_latency"}, 16'(edges), 16'(n + 2));
            if (exp_cycles >= 0) chk({tag, "_cycles"}, 16'(cycles), 16'(exp_cycles));
            chk({tag, "_busy_held"}, 16'(busy_drop), 16'd0);
            chk({tag, "_busy_off"}, 16'(busy), 16'd0);
            chk({tag, "_bin"}, bin_temperature, eb);
            chk({tag, "_int"}, 16'(bin_integer), 16'(ei));
            chk({tag, "_oor"}, 16'(out_of_range), 16'(eo));
            tick();
            chk({tag, "_done_width"}, 16'(done), 16'd0);
            chk({tag, "_idle"}, 16'(busy), 16'd0);
            exp_bin = eb; exp_int = ei; exp_oor = eo;
        end
    endtask

    initial begin
        logic [15:0] v;
        bit          s;
        int          p;

        rst_n = 1'b0; F1M = 1'b1; dec_temperature = 16'h0000;
        dec_sign = 1'b0; convert_en = 1'b0;
        #2;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_bcd_err", 16'(bcd_err), 16'd0);
        chk("rst_oor", 16'(out_of_range), 16'd0);
        chk("rst_bin", bin_temperature, 16'h0000);
        chk("rst_int", 16'(bin_integer), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        set_period(1);

        // directed cases, F1M every cycle
        run_conv(16'h0251, 1'b0, "p25_1", 1'b0, 27);
        chk("p25_1_value", bin_temperature, 16'h0192);
        chk("p25_1_intval", 16'(bin_integer), 16'h0019);
        run_conv(16'h0101, 1'b1, "n10_1", 1'b0, 12);
        chk("n10_1_value", bin_temperature, 16'hFF5E);
        run_conv(16'h0550, 1'b1, "n55_0", 1'b0, -1);
        chk("n55_0_value", bin_temperature, 16'hFC90);
        chk("n55_0_intval", 16'(bin_integer), 16'h00C9);
        run_conv(16'h0000, 1'b1, "n0_0", 1'b0, 2);
        chk("n0_0_value", bin_temperature, 16'h0000);
        run_conv(16'h0005, 1'b1, "n0_5", 1'b0, 2);
        chk("n0_5_value", bin_temperature, 16'hFFF8);
        run_conv(16'h1250, 1'b0, "p125_0", 1'b0, -1);
        chk("p125_0_value", bin_temperature, 16'h07D0);
        chk("p125_0_intval", 16'(bin_integer), 16'h007D);
        run_conv(16'h1300, 1'b0, "p130_0", 1'b0, -1);
        run_conv(16'h0600, 1'b1, "n60_0", 1'b0, -1);

        // digit error keeps previous result, next valid load clears it
        run_conv(16'h0251, 1'b0, "p25_1b", 1'b0, 27);
        run_conv(16'h02A0, 1'b0, "bad_02A0", 1'b0, -1);
        chk("bad_keep_0192", bin_temperature, 16'h0192);
        run_conv(16'h0012, 1'b0, "after_bad", 1'b0, -1);

        // slow enable, extra convert_en while busy must be ignored
        set_period(4);
        run_conv(16'h0099, 1'b0, "p9_9_slow", 1'b1, -1);
        chk("p9_9_value", bin_temperature, 16'h009E);

        // reset in the middle of a count
        set_period(1);
        dec_temperature = 16'h0990; dec_sign = 1'b0; convert_en = 1'b1;
        tick();
        convert_en = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("mid_busy", 16'(busy), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_bin", bin_temperature, 16'h0000);
        chk("abort_int", 16'(bin_integer), 16'h0000);
        chk("abort_done", 16'(done), 16'd0);
        exp_bin = 16'h0000; exp_int = 8'h00; exp_oor = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_conv(16'h0010, 1'b0, "p1_0", 1'b0, 3);
        chk("p1_0_value", bin_temperature, 16'h0010);

        // randomized requests against the model
        for (int i = 0; i < 40; i++) begin
            p = $urandom_range(1, 3);
            set_period(p);
            v = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: v[15:12] = 4'($urandom_range(10, 15));
                    1: v[11:8]  = 4'($urandom_range(10, 15));
                    2: v[7:4]   = 4'($urandom_range(10, 15));
                    default: v[3:0] = 4'($urandom_range(10, 15));
                endcase
            end
            s = 1'($urandom_range(0, 1));
            run_conv(v, s, $sformatf("rnd%0d", i), 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dec_to_bin.md
Name: dec_to_bin

Overview:
- Reverse of the sensor-side temperature path: converts an operator-entered BCD temperature (sign plus 3 integer digits and 1 tenths digit) into the DS18B20 12-bit two's-complement format, 1/16 °C per LSB, sign-extended to 16 bits.
- Also produces the signed 8-bit integer used for TH/TL alarm-register writes.
- Sits between the setpoint/keypad logic and the 1-Wire scratchpad writer.
- Iterative counter conversion, paced by the F1M clock-enable, same as the rest of the temperature datapath.

Parameters:
- MAX_POS, 125, positive magnitude limit in whole °C (used only with the clamp feature).
- MAX_NEG, 55, negative magnitude limit in whole °C (used only with the clamp feature).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- F1M  input  1  clock enable; all state advances only on clk edges with F1M=1
- dec_temperature  input  16  BCD value: [15:12] hundreds, [11:8] tens, [7:4] units, [3:0] tenths
- dec_sign  input  1  1 = negative
- convert_en  input  1  start request; sampled only in IDLE
- busy  output  1  high from load edge until the finish edge
- done  output  1  one-clk pulse when results update
- bcd_err  output  1  last request had a digit >9; sticky until next accepted load
- out_of_range  output  1  last result was saturated (0 when feature compiled out)
- bin_temperature  output  16  DS18B20 format, sign-extended
- bin_integer  output  8  signed integer part (tenths ignored, truncated toward zero)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, bcd_err and out_of_range = 0.
  - bin_temperature and bin_integer = 16'h0000 and 8'h00.
  - Internal counters = 0.
  - Reset mid-conversion aborts with no output update.
- IDLE, F1M & convert_en: latch digits and sign.
  - If any digit >9: set bcd_err, stay IDLE, no done, outputs unchanged.
  - Otherwise clear bcd_err, set busy=1, cnt_bin=0.
  - Latch frac4 from the tenths lookup 0..9 -> 0,2,3,5,6,8,10,11,13,14 (round(d*1.6)).
  - Go to COUNT.
- COUNT, per F1M edge:
  - If the BCD integer counter (hundreds/tens/units) is nonzero, decrement it by 1 with decimal borrow (units 0 -> 9 borrows from tens; tens 0 -> 9 borrows from hundreds) and increment the 8-bit cnt_bin.
  - If zero, go to FINISH.
- FINISH, one F1M edge:
  - mag = {cnt_bin[6:0], frac4} (11 bits).
  - bin_temperature = dec_sign ? -{5'b0, mag} : {5'b0, mag}, 16-bit two's complement.
  - bin_integer = dec_sign ? -cnt_bin : cnt_bin.
  - busy=0, done=1, return to IDLE.
- done: set on the FINISH edge, cleared on the very next clk edge regardless of F1M.
- Latency: integer value N (0..199) gives N+2 F1M-qualified edges from load to done.
- convert_en while busy: ignored, no queuing. Level-held convert_en restarts in the first IDLE F1M cycle after FINISH.
- Sign handling:
  - Negative zero (dec_sign=1, value 000.0) gives 16'h0000 and 8'h00.
  - -0.x gives a negative fraction only (e.g. -000.5 gives 16'hFFF8, bin_integer 8'h00).
- Without clamp, integer >127 wraps: cnt_bin[6:0] is used and the result is undefined w.r.t. the sensor. The counter itself never overflows, since 199 < 256.
- F1M=0: all registers hold, except done clears.

Optional Feature:
- Macro: DEC_TO_BIN_CLAMP_EN.
- Compiled in, FINISH checks the magnitude:
  - Positive result > MAX_POS.0 saturates to MAX_POS.0 (125 gives 16'h07D0, 8'h7D).
  - Negative magnitude > MAX_NEG.0 saturates to -MAX_NEG.0 (16'hFC90, 8'hC9).
  - Either case sets out_of_range=1.
  - Exactly MAX_POS.0 or -MAX_NEG.0 is in range.
  - out_of_range holds until the next accepted load, which clears it.
- Compiled out: no comparison, out_of_range tied 0, wrap behaviour as above.

Test Plan:
- F1M=1 each cycle, +025.1 (16'h0251, sign 0), convert_en pulse -> bin_temperature 16'h0192, bin_integer 8'h19, done exactly 27 cycles after the load edge, busy high 27 cycles.
- -010.1 (16'h0101, sign 1) -> 16'hFF5E, 8'hF6; -055.0 -> 16'hFC90, 8'hC9; -000.0 -> 16'h0000.
- +125.0 -> 16'h07D0, 8'h7D; with DEC_TO_BIN_CLAMP_EN, +130.0 -> 16'h07D0 and out_of_range=1; -060.0 -> 16'hFC90 and out_of_range=1.
- Digit error 16'h02A0 -> bcd_err=1, no done, outputs keep previous 16'h0192; next valid request clears bcd_err.
- F1M high one cycle in four, +009.9 -> 16'h009E after 11 F1M edges; second convert_en while busy is ignored; done is exactly one clk wide.
- rst_n low during COUNT of +099.0 -> all outputs 0 immediately; after release, +001.0 -> 16'h0010.
